// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one or two stop bits. Outputs are registered from the next state so they align with it.
module uart_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  stop_last;
    logic                  ready;
    logic                  accept;

    // stop_cnt counts 0 (one stop bit) or 0..1 (two stop bits)
    assign stop_last = (stop_cnt_q == stop2_q);
    assign ready     = (state_q == StIdle) || ((state_q == StStop) && stop_last);
    assign accept    = ready && Data_Valid;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        done_d     = 1'b0;

        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            stop2_d   = STOP2;
        end

        case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: begin
                state_d   = StData;
                bit_cnt_d = '0;
            end
            StData: begin
                if (bit_cnt_q == LastBit) begin
                    state_d    = par_en_q ? StParity : StStop;
                    stop_cnt_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StParity: begin
                state_d    = StStop;
                stop_cnt_d = 1'b0;
            end
            StStop: begin
                if (!stop_last) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = accept ? StStart : StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
            end
        endcase

        // Line level follows the state being entered at this edge
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_cnt_d];
            StParity: tx_d = (^data_d) ^ par_typ_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Parametrised UART transmit engine: controller, serializer, parity generator and output mux in one block. It accepts a parallel word of `DATA_WIDTH` bits on a valid strobe and shifts out one frame, LSB first, one bit per `clk` cycle:
- start bit;
- `DATA_WIDTH` data bits;
- optional even/odd parity bit;
- one or two stop bits.

`clk` is the already-divided TX bit clock. The block sits between the system-side data source and the TX pin. It adds configurable word width, parity type, stop-bit count, back-to-back frames and a done pulse.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..16.
- `clk` input 1: TX bit clock; all state updates on rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `P_DATA` input DATA_WIDTH: parallel word; sampled only on accept.
- `Data_Valid` input 1: request to send `P_DATA`; honoured only when `ready` condition holds.
- `PAR_EN` input 1: 1 = parity bit inserted; sampled on accept.
- `PAR_TYP` input 1: 0 = even, 1 = odd; sampled on accept.
- `STOP2` input 1: 1 = two stop bits, 0 = one; sampled on accept.
- `TX_OUT` output 1: serial line, registered; idle level 1.
- `busy` output 1: registered; 1 while a frame is on the line.
- `tx_done` output 1: registered; one-cycle pulse in the cycle after the final stop bit of a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition ("ready"): state IDLE, or state STOP on its final stop bit.
  - At an edge where ready and `Data_Valid`=1, the block latches `P_DATA`, `PAR_EN`, `PAR_TYP`, `STOP2` into shadow registers.
  - `Data_Valid` at any other time is ignored; no queuing and no error.
- Parity is computed from the latched word: even = XOR of all data bits; odd = inverted XOR.
- Transitions:
  - IDLE→START on accept.
  - START→DATA after 1 cycle.
  - DATA→PARITY, or →STOP if parity is disabled, after `DATA_WIDTH` cycles.
  - PARITY→STOP after 1 cycle.
  - STOP lasts 1 or 2 cycles. On its final cycle: →START if accept, else →IDLE.
- Line value by state: START=0, DATA=latched bit[bit_cnt] (bit_cnt 0..DATA_WIDTH-1, LSB first), PARITY=parity bit, STOP=1, IDLE=1.
- `bit_cnt` is $clog2(DATA_WIDTH) bits wide. It clears on entry to DATA and never wraps past DATA_WIDTH-1.
- Shadow registers hold their value for the whole frame. Changing the inputs mid-frame has no effect.
- Illegal or unreachable state encoding: the next edge forces IDLE, `TX_OUT`=1, `busy`=0.

## Timing
- Reset (`RST`=0, asynchronous): state IDLE, `TX_OUT`=1, `busy`=0, `tx_done`=0, counters and shadows 0. This applies immediately, including mid-frame; the frame in flight is aborted, not completed.
- After reset release, the first accept can occur at the first rising edge.
- Latency: accept at edge k → `TX_OUT`=0 (start bit) and `busy`=1 from edge k.
- Frame length L = 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) cycles. The final stop bit is driven from edge k+L-1 to edge k+L.
- Without a new accept, at edge k+L: `TX_OUT`=1 (idle), `busy`=0, `tx_done`=1 for exactly one cycle.
- Back-to-back: an accept on the final stop bit makes edge k+L start the next frame.
  - Start bit `TX_OUT`=0, `busy` stays 1, no idle gap.
  - `tx_done`=1 for one cycle, for the completed frame.
- Accept pulse semantics: a `Data_Valid` held high continuously sends consecutive frames with zero idle cycles; each frame latches `P_DATA` current at its accept edge.

## Test plan
- Reset, then hold idle 10 cycles → `TX_OUT`=1, `busy`=0, `tx_done`=0 throughout.
- DATA_WIDTH=8, `P_DATA`=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0, one-cycle `Data_Valid` → line 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop). `busy`=1 for 11 cycles, then `tx_done` pulses once.
- Same word with PAR_TYP=1, STOP2=1 → parity bit 1, two stop bits, frame 12 cycles. PAR_EN=0, STOP2=0 → 10 cycles, no parity bit.
- `Data_Valid` held high with words 0x00 then 0xFF, PAR_EN=0 → two 10-bit frames with no idle bit between. `busy` stays 1 and `tx_done` pulses at each frame end. A `Data_Valid` pulse mid-frame (DATA state) with 0x3C → ignored; 0x3C never appears on the line.
- Change `P_DATA`, `PAR_EN` and `STOP2` during DATA → current frame unchanged.
- Assert `RST` low during bit 4 of the data field → `TX_OUT`=1 and `busy`=0 immediately (asynchronously). After release, a new frame (0x5A) transmits correctly.
- DATA_WIDTH=5 and DATA_WIDTH=16 builds, `P_DATA` all-ones with even parity → parity 1 (5 ones, odd count) and 0 (16 ones) respectively. Frame lengths are 8 and 19 cycles with PAR_EN=1, STOP2=0.
